alu_wb_stage: RTL and testbench

- Execute-to-writeback stage directly downstream of the ALU.
- Captures the ALU result and PSW update (psw_out under psw_msk) and holds the architectural PSW register.
- Feeds carry back to the ALU's carry_in.
- Drives the register-file write port through a valid/ready handshake, since the port is shared with load writeback.
- Provides a bypass value for operand forwarding.

---
 rtl/xm23_pkg.sv | 28 ++
 rtl/psw_reg.sv | 46 ++++
 rtl/alu_wb_stage.sv | 102 ++++++++++
 tb/tb_alu_wb_stage.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/xm23_pkg.sv
// Shared XM23 definitions: PSW bit layout, PSW reset value and the
// writeback entry type used between execute and the register file.
package xm23_pkg;

   localparam int XM_DW = 16;
   localparam int XM_RW = 3;

   // PSW bit positions
   localparam int PSW_C       = 0;
   localparam int PSW_Z       = 1;
   localparam int PSW_N       = 2;
   localparam int PSW_SLP     = 3;
   localparam int PSW_V       = 4;
   localparam int PSW_PRI_LO  = 5;
   localparam int PSW_PRI_HI  = 7;
   localparam int PSW_FLT     = 8;
   localparam int PSW_PPRI_LO = 13;
   localparam int PSW_PPRI_HI = 15;

   // Priority 7, all condition flags clear
   localparam logic [15:0] PSW_RST = 16'h00E0;

   typedef struct packed {
      logic [XM_RW-1:0] dst;
      logic [XM_DW-1:0] data;
   } wb_entry_t;

endpackage : xm23_pkg

// File: rtl/psw_reg.sv
// Architectural PSW register: merges the ALU flag update under its mask,
// then applies SETCC and CLRCC (clear wins over set).
module psw_reg
#(
   parameter logic [15:0] RST_VAL = 16'h00E0
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        upd_i,
   input  logic [15:0] psw_out_i,
   input  logic [15:0] psw_msk_i,
   input  logic [4:0]  cc_set_i,
   input  logic [4:0]  cc_clr_i,
   output logic [15:0] psw_o
);
   import xm23_pkg::*;

   logic [15:0] psw_q;
   logic [15:0] psw_d;
   logic [15:0] merged_s;

   // Next PSW: ALU merge on an accepted op, then SETCC, then CLRCC
   always_comb begin
      merged_s = psw_q;
      if (upd_i) begin
         merged_s = (psw_q & ~psw_msk_i) | (psw_out_i & psw_msk_i);
      end else begin
         merged_s = psw_q;
      end
      psw_d = merged_s;
      psw_d[PSW_V:PSW_C] = (merged_s[PSW_V:PSW_C] | cc_set_i) & ~cc_clr_i;
   end

   // PSW state register, restored to the reset value asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         psw_q <= RST_VAL;
      end else begin
         psw_q <= psw_d;
      end
   end

   assign psw_o = psw_q;

endmodule : psw_reg

// File: rtl/alu_wb_stage.sv
// Execute-to-writeback stage: single-entry holding register feeding the
// shared register-file write port, forwarding tap, and the PSW.
module alu_wb_stage
#(
   parameter int          DW      = 16,
   parameter int          RW      = 3,
   parameter logic [15:0] PSW_RST = 16'h00E0
)
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_result,
   input  logic [15:0]   in_psw_out,
   input  logic [15:0]   in_psw_msk,
   input  logic [RW-1:0] in_dst,
   input  logic          in_wr_en,
   input  logic [4:0]    cc_set,
   input  logic [4:0]    cc_clr,
   input  logic          flush,
   output logic          wb_valid,
   input  logic          wb_ready,
   output logic [RW-1:0] wb_dst,
   output logic [DW-1:0] wb_data,
   output logic          fwd_valid,
   output logic [RW-1:0] fwd_dst,
   output logic [DW-1:0] fwd_data,
   output logic [15:0]   psw,
   output logic          carry_out
);
   import xm23_pkg::*;

   logic          valid_q;
   logic          valid_d;
   logic [RW-1:0] dst_q;
   logic [RW-1:0] dst_d;
   logic [DW-1:0] data_q;
   logic [DW-1:0] data_d;
   logic          acc_s;
   logic          load_s;

   // A drain and a fill may share a cycle, so ready depends on wb_ready
   assign in_ready = ~valid_q | wb_ready;
   assign acc_s    = in_valid & in_ready;
   assign load_s   = acc_s & in_wr_en;

   // Holding register next state: a new write beats flush, flush beats drain
   always_comb begin
      valid_d = valid_q;
      dst_d   = dst_q;
      data_d  = data_q;
      if (load_s) begin
         valid_d = 1'b1;
         dst_d   = in_dst;
         data_d  = in_result;
      end else if (flush) begin
         valid_d = 1'b0;
      end else if (valid_q && wb_ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // Holding register; index and data are left untouched when empty
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         dst_q   <= {RW{1'b0}};
         data_q  <= {DW{1'b0}};
      end else begin
         valid_q <= valid_d;
         dst_q   <= dst_d;
         data_q  <= data_d;
      end
   end

   // A flushed entry must not be written in the cycle it is discarded
   assign wb_valid  = valid_q & ~flush;
   assign wb_dst    = dst_q;
   assign wb_data   = data_q;
   assign fwd_valid = wb_valid;
   assign fwd_dst   = dst_q;
   assign fwd_data  = data_q;

   psw_reg #(
      .RST_VAL (PSW_RST)
   ) u_psw_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .upd_i     (acc_s),
      .psw_out_i (in_psw_out),
      .psw_msk_i (in_psw_msk),
      .cc_set_i  (cc_set),
      .cc_clr_i  (cc_clr),
      .psw_o     (psw)
   );

   assign carry_out = psw[PSW_C];

endmodule : alu_wb_stage

// File: tb/tb_alu_wb_stage.sv
// Directed testbench for alu_wb_stage.
module tb_alu_wb_stage;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_result;
   logic [15:0] in_psw_out;
   logic [15:0] in_psw_msk;
   logic [2:0]  in_dst;
   logic        in_wr_en;
   logic [4:0]  cc_set;
   logic [4:0]  cc_clr;
   logic        flush;
   logic        wb_valid;
   logic        wb_ready;
   logic [2:0]  wb_dst;
   logic [15:0] wb_data;
   logic        fwd_valid;
   logic [2:0]  fwd_dst;
   logic [15:0] fwd_data;
   logic [15:0] psw;
   logic        carry_out;

   int vectors;
   int miscompares;

   alu_wb_stage #(.DW(16), .RW(3), .PSW_RST(16'h00E0)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_result  (in_result),
      .in_psw_out (in_psw_out),
      .in_psw_msk (in_psw_msk),
      .in_dst     (in_dst),
      .in_wr_en   (in_wr_en),
      .cc_set     (cc_set),
      .cc_clr     (cc_clr),
      .flush      (flush),
      .wb_valid   (wb_valid),
      .wb_ready   (wb_ready),
      .wb_dst     (wb_dst),
      .wb_data    (wb_data),
      .fwd_valid  (fwd_valid),
      .fwd_dst    (fwd_dst),
      .fwd_data   (fwd_data),
      .psw        (psw),
      .carry_out  (carry_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic op(input logic [15:0] res, input logic [2:0] dst, input logic wr,
                     input logic [15:0] msk, input logic [15:0] pout);
      in_valid   = 1'b1;
      in_result  = res;
      in_dst     = dst;
      in_wr_en   = wr;
      in_psw_msk = msk;
      in_psw_out = pout;
   endtask

   task automatic idle();
      in_valid   = 1'b0;
      in_wr_en   = 1'b0;
      in_psw_msk = 16'h0000;
      in_psw_out = 16'h0000;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      in_result = 16'h0000; in_dst = 3'd0;
      cc_set = 5'b00000; cc_clr = 5'b00000; flush = 1'b0; wb_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      vectors++; if (psw !== 16'h00E0) begin miscompares++; $display("FAIL rst_psw: got %h want %h", psw, 16'h00E0); end
      vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL rst_wb_valid: got %b want 0", wb_valid); end
      vectors++; if (fwd_valid !== 1'b0) begin miscompares++; $display("FAIL rst_fwd_valid: got %b want 0", fwd_valid); end
      vectors++; if (wb_dst !== 3'd0) begin miscompares++; $display("FAIL rst_wb_dst: got %0d want 0", wb_dst); end
      vectors++; if (wb_data !== 16'h0000) begin miscompares++; $display("FAIL rst_wb_data: got %h want 0000", wb_data); end
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
      vectors++; if (carry_out !== 1'b0) begin miscompares++; $display("FAIL rst_carry: got %b want 0", carry_out); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_add();
      wb_ready = 1'b1;
      op(16'h1234, 3'd2, 1'b1, 16'h001F, 16'h0001);
      tick();
      idle();
      vectors++; if (wb_valid !== 1'b1) begin miscompares++; $display("FAIL add_wb_valid: got %b want 1", wb_valid); end
      vectors++; if (wb_dst !== 3'd2) begin miscompares++; $display("FAIL add_wb_dst: got %0d want 2", wb_dst); end
      vectors++; if (wb_data !== 16'h1234) begin miscompares++; $display("FAIL add_wb_data: got %h want 1234", wb_data); end
      vectors++; if (psw !== 16'h00E1) begin miscompares++; $display("FAIL add_psw: got %h want 00E1", psw); end
      vectors++; if (carry_out !== 1'b1) begin miscompares++; $display("FAIL add_carry: got %b want 1", carry_out); end
      vectors++; if (fwd_valid !== 1'b1 || fwd_dst !== 3'd2 || fwd_data !== 16'h1234) begin miscompares++; $display("FAIL add_fwd: got %b/%0d/%h want 1/2/1234", fwd_valid, fwd_dst, fwd_data); end
      tick();
      vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL add_drain: got %b want 0", wb_valid); end
      vectors++; if (wb_data !== 16'h1234) begin miscompares++; $display("FAIL add_hold_data: got %h want 1234", wb_data); end
   endtask

   task automatic test_back_to_back();
      // ADD producing C=0, then ADDC consuming it with no bubble
      op(16'h0001, 3'd1, 1'b1, 16'h001F, 16'h0000);
      tick();
      op(16'h0002, 3'd3, 1'b1, 16'h001F, 16'h0001);
      #1;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready: got %b want 1", in_ready); end
      vectors++; if (carry_out !== 1'b0) begin miscompares++; $display("FAIL b2b_carry_in: got %b want 0", carry_out); end
      vectors++; if (wb_data !== 16'h0001) begin miscompares++; $display("FAIL b2b_first_data: got %h want 0001", wb_data); end
      tick();
      idle();
      vectors++; if (carry_out !== 1'b1) begin miscompares++; $display("FAIL b2b_carry_next: got %b want 1", carry_out); end
      vectors++; if (wb_dst !== 3'd3 || wb_data !== 16'h0002) begin miscompares++; $display("FAIL b2b_second: got %0d/%h want 3/0002", wb_dst, wb_data); end
      tick();
   endtask

   task automatic test_backpressure();
      wb_ready = 1'b0;
      op(16'hBEEF, 3'd5, 1'b1, 16'h0000, 16'h0000);
      tick();
      op(16'h5555, 3'd6, 1'b1, 16'h0000, 16'h0000);
      for (int i = 0; i < 3; i++) begin
         vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready[%0d]: got %b want 0", i, in_ready); end
         vectors++; if (wb_valid !== 1'b1 || wb_data !== 16'hBEEF || wb_dst !== 3'd5) begin miscompares++; $display("FAIL bp_hold[%0d]: got %b/%0d/%h want 1/5/BEEF", i, wb_valid, wb_dst, wb_data); end
         tick();
      end
      wb_ready = 1'b1;
      #1;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
      tick();
      idle();
      vectors++; if (wb_valid !== 1'b1 || wb_data !== 16'h5555 || wb_dst !== 3'd6) begin miscompares++; $display("FAIL bp_refill: got %b/%0d/%h want 1/6/5555", wb_valid, wb_dst, wb_data); end
      tick();
      vectors++; if (psw !== 16'h00E1) begin miscompares++; $display("FAIL bp_psw: got %h want 00E1", psw); end
   endtask

   task automatic test_bit();
      op(16'h0000, 3'd0, 1'b0, 16'h0006, 16'h0002);
      tick();
      idle();
      vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL bit_wb_valid: got %b want 0", wb_valid); end
      vectors++; if (psw !== 16'h00E3) begin miscompares++; $display("FAIL bit_psw: got %h want 00E3", psw); end
      vectors++; if (carry_out !== 1'b1) begin miscompares++; $display("FAIL bit_carry: got %b want 1", carry_out); end
   endtask

   task automatic test_cc();
      // ALU sets C, SETCC C, CLRCC C: clear wins
      op(16'h0000, 3'd0, 1'b0, 16'h0001, 16'h0001);
      cc_set = 5'b00001; cc_clr = 5'b00001;
      tick();
      idle();
      cc_set = 5'b00000; cc_clr = 5'b00000;
      vectors++; if (psw !== 16'h00E2) begin miscompares++; $display("FAIL cc_clr_wins: got %h want 00E2", psw); end
      vectors++; if (carry_out !== 1'b0) begin miscompares++; $display("FAIL cc_carry: got %b want 0", carry_out); end
      cc_set = 5'b00100;
      tick();
      cc_set = 5'b00000;
      vectors++; if (psw !== 16'h00E6) begin miscompares++; $display("FAIL cc_set_n: got %h want 00E6", psw); end
      cc_clr = 5'b00010;
      tick();
      cc_clr = 5'b00000;
      vectors++; if (psw !== 16'h00E4) begin miscompares++; $display("FAIL cc_clr_z: got %h want 00E4", psw); end
   endtask

   task automatic test_flush();
      wb_ready = 1'b0;
      op(16'hCAFE, 3'd7, 1'b1, 16'h0000, 16'h0000);
      tick();
      idle();
      wb_ready = 1'b1;
      flush = 1'b1;
      #1;
      vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL flush_suppress: got %b want 0", wb_valid); end
      vectors++; if (fwd_valid !== 1'b0) begin miscompares++; $display("FAIL flush_fwd: got %b want 0", fwd_valid); end
      tick();
      flush = 1'b0;
      #1;
      vectors++; if (wb_valid !== 1'b0 || wb_data !== 16'hCAFE) begin miscompares++; $display("FAIL flush_empty: got %b/%h want 0/CAFE", wb_valid, wb_data); end
      // Refill, then flush together with a new writing op (PSW still updates)
      wb_ready = 1'b0;
      op(16'hCAFE, 3'd7, 1'b1, 16'h0000, 16'h0000);
      tick();
      wb_ready = 1'b1;
      flush = 1'b1;
      op(16'h1111, 3'd4, 1'b1, 16'h001F, 16'h0010);
      tick();
      idle();
      flush = 1'b0;
      wb_ready = 1'b0;
      #1;
      vectors++; if (wb_valid !== 1'b1 || wb_dst !== 3'd4 || wb_data !== 16'h1111) begin miscompares++; $display("FAIL flush_acc: got %b/%0d/%h want 1/4/1111", wb_valid, wb_dst, wb_data); end
      vectors++; if (psw !== 16'h00F0) begin miscompares++; $display("FAIL flush_psw: got %h want 00F0", psw); end
   endtask

   task automatic test_reset_mid();
      #2;
      rst_n = 1'b0;
      #1;
      vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_wb_valid: got %b want 0", wb_valid); end
      vectors++; if (psw !== 16'h00E0) begin miscompares++; $display("FAIL rmid_psw: got %h want 00E0", psw); end
      vectors++; if (wb_data !== 16'h0000 || wb_dst !== 3'd0) begin miscompares++; $display("FAIL rmid_entry: got %0d/%h want 0/0000", wb_dst, wb_data); end
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rmid_ready: got %b want 1", in_ready); end
      #2;
      rst_n = 1'b1;
      tick();
      vectors++; if (wb_valid !== 1'b0 || psw !== 16'h00E0) begin miscompares++; $display("FAIL rmid_after: got %b/%h want 0/00E0", wb_valid, psw); end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      test_reset();
      test_add();
      test_back_to_back();
      test_backpressure();
      test_bit();
      test_cc();
      test_flush();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_alu_wb_stage
